ym_reg_sched: RTL and testbench

- Write scheduler for the Sunsoft-5B/YM2149 sound core register port used by mapper 069.
- Keeps a 16x8 shadow copy of all sound registers and arbitrates the core's single write port between two sources:
  - live CPU writes (address latch at $C000, data at $E000);
  - a save-state restore engine that replays the shadow file into the core.
- Sits between the mapper's CPU address decode and the sound core. The sound core's registers are not readable, so this block is also the save-state source for sound registers.

---
 rtl/ym_reg_sched.sv | 137 +++++++++++++
 tb/tb_ym_reg_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_reg_sched.sv
// Write scheduler for the Sunsoft-5B/YM2149 register port: 16x8 shadow file, CPU pass-through
// and a paced save-state restore engine. Optional YM_SCHED_MUTE_EN: mixer-last order plus mute request.
module ym_reg_sched #(
    parameter int NREG   = 16,
    parameter int WR_GAP = 2
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       cpu_we,
    input  logic       cpu_sel,
    input  logic [7:0] cpu_dat,
    input  logic       sst_we,
    input  logic [3:0] sst_addr,
    input  logic [7:0] sst_dat,
    output logic [7:0] sst_rd_dat,
    input  logic       restore_req,
    output logic       ym_we,
    output logic [3:0] ym_addr,
    output logic [7:0] ym_dat,
    output logic       busy,
    output logic       done,
    output logic       ym_mute
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] shadow [NREG];
    logic [3:0] raddr;
    logic [3:0] pos;
    logic [3:0] gap;
    logic [3:0] idx;
    logic       cpu_data_wr;

    // Replay position to register index; the mixer (R7) goes last when muting is built in.
    function automatic logic [3:0] restore_order(input logic [3:0] p);
`ifdef YM_SCHED_MUTE_EN
        if (p < 4'd7)
            return p;
        else if (p < 4'd15)
            return p + 4'd1;
        else
            return 4'd7;
`else
        return p;
`endif
    endfunction

    assign cpu_data_wr = cpu_we & cpu_sel;
    assign idx         = restore_order(pos);
    assign sst_rd_dat  = shadow[sst_addr];

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state   <= IDLE;
            raddr   <= 4'd0;
            pos     <= 4'd0;
            gap     <= 4'd0;
            ym_we   <= 1'b0;
            ym_addr <= 4'd0;
            ym_dat  <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < NREG; i++)
                shadow[i] <= 8'h00;
        end else begin
            ym_we <= 1'b0;
            done  <= 1'b0;

            // The CPU assignment comes second so it wins a same-index collision.
            if (sst_we)
                shadow[sst_addr] <= sst_dat;
            if (cpu_we && !cpu_sel)
                raddr <= cpu_dat[3:0];
            if (cpu_data_wr) begin
                shadow[raddr] <= cpu_dat;
                ym_we         <= 1'b1;
                ym_addr       <= raddr;
                ym_dat        <= cpu_dat;
            end

            case (state)
                IDLE: begin
                    if (restore_req) begin
                        state <= RUN;
                        pos   <= 4'd0;
                        gap   <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (gap != 4'd0) begin
                        gap <= gap - 4'd1;
                    end else if (!cpu_data_wr) begin
                        ym_we   <= 1'b1;
                        ym_addr <= idx;
                        ym_dat  <= shadow[idx];
                        gap     <= 4'(WR_GAP - 1);
                        if (pos == 4'(NREG - 1))
                            state <= FIN;
                        else
                            pos <= pos + 4'd1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef YM_SCHED_MUTE_EN
    logic mute_q;

    // Held from acceptance through the done cycle inclusive.
    always_ff @(posedge clk) begin
        if (map_rst)
            mute_q <= 1'b0;
        else if (state == IDLE && restore_req)
            mute_q <= 1'b1;
        else if (done)
            mute_q <= 1'b0;
    end

    assign ym_mute = mute_q;
`else
    assign ym_mute = 1'b0;
`endif

endmodule

// File: tb/tb_ym_reg_sched.sv
// Directed bench for ym_reg_sched: CPU path, paced restore, CPU/restore collision,
// repeated restore request and mid-restore reset.
module tb_ym_reg_sched;

    logic       clk = 1'b0;
    logic       map_rst = 1'b1;
    logic       cpu_we = 1'b0;
    logic       cpu_sel = 1'b0;
    logic [7:0] cpu_dat = 8'h00;
    logic       sst_we = 1'b0;
    logic [3:0] sst_addr = 4'd0;
    logic [7:0] sst_dat = 8'h00;
    logic [7:0] sst_rd_dat;
    logic       restore_req = 1'b0;
    logic       ym_we;
    logic [3:0] ym_addr;
    logic [7:0] ym_dat;
    logic       busy;
    logic       done;
    logic       ym_mute;

`ifdef YM_SCHED_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    ym_reg_sched #(.NREG(16), .WR_GAP(2)) dut (
        .clk(clk), .map_rst(map_rst),
        .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_dat(cpu_dat),
        .sst_we(sst_we), .sst_addr(sst_addr), .sst_dat(sst_dat), .sst_rd_dat(sst_rd_dat),
        .restore_req(restore_req),
        .ym_we(ym_we), .ym_addr(ym_addr), .ym_dat(ym_dat),
        .busy(busy), .done(done), .ym_mute(ym_mute)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [3:0] log_addr[$];
    logic [7:0] log_dat[$];
    int         log_cyc[$];
    int         done_cnt = 0;
    int         mute_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ym_we) begin
            log_addr.push_back(ym_addr);
            log_dat.push_back(ym_dat);
            log_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (ym_mute !== (MUTE ? (busy | done) : 1'b0)) mute_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ord(input int k);
        if (MUTE) begin
            if (k < 7) return 4'(k);
            else if (k < 15) return 4'(k + 1);
            else return 4'd7;
        end
        return 4'(k);
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_dat.delete();
        log_cyc.delete();
        done_cnt = 0;
        mute_bad = 0;
    endtask

    task automatic cpu_wr(input logic sel, input logic [7:0] d);
        @(negedge clk);
        cpu_we = 1'b1; cpu_sel = sel; cpu_dat = d;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic load_shadow();
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            sst_we = 1'b1; sst_addr = 4'(n); sst_dat = 8'h10 + 8'(n);
        end
        @(negedge clk);
        sst_we = 1'b0;
    endtask

    task automatic start_restore();
        @(negedge clk);
        restore_req = 1'b1;
        @(negedge clk);
        restore_req = 1'b0;
    endtask

    // Counts edges from acceptance until done is visible; bounded.
    task automatic wait_done(output int n, output int busy_low);
        n = 1;
        busy_low = 0;
        while (!done && n < 300) begin
            if (!busy) busy_low++;
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bl, bad, t, nz, j;
        logic [7:0] e;

        repeat (3) @(negedge clk);
        map_rst = 1'b0;
        chk("rst_ym_we", ym_we, 0);
        chk("rst_ym_addr", ym_addr, 0);
        chk("rst_ym_dat", ym_dat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mute", ym_mute, 0);
        chk("rst_shadow0", sst_rd_dat, 0);

        // CPU path
        cpu_wr(1'b0, 8'h08);
        chk("latch_no_we", ym_we, 0);
        cpu_wr(1'b1, 8'h0F);
        chk("cpu_we", ym_we, 1);
        chk("cpu_addr", ym_addr, 4'd8);
        chk("cpu_dat", ym_dat, 8'h0F);
        @(negedge clk);
        chk("cpu_we_pulse", ym_we, 0);
        sst_addr = 4'd8;
        #1 chk("cpu_shadow8", sst_rd_dat, 8'h0F);

        // Plain restore
        load_shadow();
        clear_log();
        start_restore();
        chk("busy_start", busy, 1);
        chk("mute_start", ym_mute, MUTE);
        wait_done(n, bl);
        chk("busy_hold", bl, 0);
        chk("restore_len", n >= 31, 1);
        @(negedge clk);
        chk("busy_end", busy, 0);
        chk("done_once", done_cnt, 1);
        chk("wr_count", log_addr.size(), 16);
        if (log_addr.size() == 16) begin
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                chk("rs_addr", log_addr[k], ord(k));
                chk("rs_dat", log_dat[k], 8'h10 + 8'(ord(k)));
                if (k > 0 && log_cyc[k] - log_cyc[k-1] != 2) bad++;
            end
            chk("rs_spacing", bad, 0);
        end
        chk("mute_window", mute_bad, 0);

        // CPU data write lands in the cycle a restore write is due
        cpu_wr(1'b0, 8'hF3);
        clear_log();
        @(negedge clk); restore_req = 1'b1;
        @(negedge clk); restore_req = 1'b0;
        @(negedge clk);
        @(negedge clk); cpu_we = 1'b1; cpu_sel = 1'b1; cpu_dat = 8'hAA;
        @(negedge clk); cpu_we = 1'b0;
        wait_done(n, bl);
        @(negedge clk);
        chk("col_count", log_addr.size(), 17);
        chk("col_done", done_cnt, 1);
        if (log_addr.size() == 17) begin
            chk("col_cpu_addr", log_addr[1], 4'd3);
            chk("col_cpu_dat", log_dat[1], 8'hAA);
            chk("col_cpu_slot", log_cyc[1] - log_cyc[0], 2);
            chk("col_delayed", (log_cyc[2] - log_cyc[0]) >= 3, 1);
            for (int k = 0; k < 16; k++) begin
                j = (k < 1) ? k : k + 1;
                e = (ord(k) == 4'd3) ? 8'hAA : 8'h10 + 8'(ord(k));
                chk("col_addr", log_addr[j], ord(k));
                chk("col_dat", log_dat[j], e);
            end
        end
        sst_addr = 4'd3;
        #1 chk("col_shadow3", sst_rd_dat, 8'hAA);

        // Second restore_req while busy is ignored
        load_shadow();
        clear_log();
        start_restore();
        repeat (5) @(negedge clk);
        restore_req = 1'b1;
        @(negedge clk);
        restore_req = 1'b0;
        wait_done(n, bl);
        repeat (40) @(negedge clk);
        chk("dbl_count", log_addr.size(), 16);
        chk("dbl_done", done_cnt, 1);
        chk("dbl_busy", busy, 0);

        // Reset after the 5th restore write
        clear_log();
        start_restore();
        t = 0;
        while (log_addr.size() < 5 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("fifth_seen", log_addr.size() >= 5, 1);
        map_rst = 1'b1;
        @(negedge clk);
        map_rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_wr_count", log_addr.size(), 5);
        chk("rst_busy_mid", busy, 0);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_mute_mid", ym_mute, 0);
        nz = 0;
        for (int k = 0; k < 16; k++) begin
            sst_addr = 4'(k);
            #1 if (sst_rd_dat !== 8'h00) nz++;
        end
        chk("rst_shadow_clr", nz, 0);
        cpu_wr(1'b1, 8'h5C);
        chk("rst_raddr", ym_addr, 4'd0);
        chk("rst_raddr_dat", ym_dat, 8'h5C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
